dmem_access_ctrl: RTL and testbench

- Memory-stage data-memory interface feeding the writeback pipeline register. Takes load/store commands from the M stage, runs a req/ack transaction to data memory, and formats load data.
- Generates the pipeline stall that freezes the upstream and writeback registers while an access is outstanding.
- Produces ld_data for the W stage. Handles byte/half/word sizing, sign extension, misalignment and a bounded-wait timeout.

---
 rtl/dmem_access_ctrl_if.sv | 29 ++
 rtl/dmem_access_ctrl.sv | 155 +++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_access_ctrl_if.sv
// Data-memory request/response bus between the M-stage access controller and data memory.
//   master : controller side (drives dm_req/dm_we/dm_addr/dm_wdata, samples dm_ack/dm_rdata)
//   slave  : memory side (samples the request, returns dm_ack/dm_rdata)
interface dmem_access_ctrl_if;
    logic        dm_req;
    logic [3:0]  dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;

    modport master (
        output dm_req,
        output dm_we,
        output dm_addr,
        output dm_wdata,
        input  dm_ack,
        input  dm_rdata
    );

    modport slave (
        input  dm_req,
        input  dm_we,
        input  dm_addr,
        input  dm_wdata,
        output dm_ack,
        output dm_rdata
    );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Memory-stage data-memory access controller feeding the writeback register.
// Runs one req/ack transaction per load/store, stalls the pipeline while it is
// outstanding, formats load data and rejects misaligned or timed-out accesses.
//   clk, rst              : clock, asynchronous active-low reset
//   mem_read, mem_write   : M-stage load/store command (held stable while stall=1)
//   funct3, addr          : access size/sign and byte address
//   store_data            : right-aligned store data
//   dm                    : data-memory bus (master side)
//   ld_data               : formatted load result for the W stage
//   stall                 : combinational pipeline hold
//   misalign, timeout     : one-cycle pulses in the DONE cycle of a rejected/aborted access
module dmem_access_ctrl #(
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       mem_read,
    input  logic                       mem_write,
    input  logic [2:0]                 funct3,
    input  logic [31:0]                addr,
    input  logic [31:0]                store_data,
    dmem_access_ctrl_if.master         dm,
    output logic [31:0]                ld_data,
    output logic                       stall,
    output logic                       misalign,
    output logic                       timeout
);

    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   wait_cnt;
    logic               is_load_q;
    logic [2:0]         f3_q;
    logic [1:0]         off_q;

    logic [3:0]         lane_we_c;
    logic [31:0]        lane_wdata_c;
    logic               misaligned_c;

    // Byte/half selection with sign or zero extension; everything else is a word.
    function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = off[1] ? w[31:16] : w[15:0];
        case (f3[1:0])
            2'b00:   fmt_load = f3[2] ? {24'd0, b} : {{24{b[7]}}, b};
            2'b01:   fmt_load = f3[2] ? {16'd0, h} : {{16{h[15]}}, h};
            default: fmt_load = w;
        endcase
    endfunction

    // Lane enables, replicated store data and alignment check; funct3[1]=1 covers W and illegal codes.
    always_comb begin
        lane_we_c    = 4'b1111;
        lane_wdata_c = store_data;
        misaligned_c = |addr[1:0];
        case (funct3[1:0])
            2'b00: begin
                lane_we_c    = 4'b0001 << addr[1:0];
                lane_wdata_c = {4{store_data[7:0]}};
                misaligned_c = 1'b0;
            end
            2'b01: begin
                lane_we_c    = 4'b0011 << addr[1:0];
                lane_wdata_c = {2{store_data[15:0]}};
                misaligned_c = addr[0];
            end
            default: ;
        endcase
    end

    // The pipeline advances only on the edge that ends the DONE cycle.
    assign stall = (mem_read | mem_write) && (state != DONE);

    // Access FSM with registered bus outputs, result and status pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            is_load_q   <= 1'b0;
            f3_q        <= 3'd0;
            off_q       <= 2'd0;
            dm.dm_req   <= 1'b0;
            dm.dm_we    <= 4'd0;
            dm.dm_addr  <= 32'd0;
            dm.dm_wdata <= 32'd0;
            ld_data     <= 32'd0;
            misalign    <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            misalign <= 1'b0;
            timeout  <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_read | mem_write) begin
                        is_load_q <= mem_read;
                        f3_q      <= funct3;
                        off_q     <= addr[1:0];
                        if (misaligned_c) begin
                            state    <= DONE;
                            ld_data  <= 32'd0;
                            misalign <= 1'b1;
                        end else begin
                            state       <= REQ;
                            dm.dm_req   <= 1'b1;
                            dm.dm_addr  <= {addr[31:2], 2'b00};
                            dm.dm_we    <= mem_write ? lane_we_c : 4'd0;
                            dm.dm_wdata <= mem_write ? lane_wdata_c : 32'd0;
                        end
                    end
                end
                REQ: begin
                    if (dm.dm_ack) begin
                        state     <= DONE;
                        dm.dm_req <= 1'b0;
                        wait_cnt  <= '0;
                        if (is_load_q) begin
                            ld_data <= fmt_load(f3_q, off_q, dm.dm_rdata);
                        end
                    end else if (wait_cnt == CNT_W'(MAX_WAIT - 1)) begin
                        // Last allowed REQ cycle without an ack: abort.
                        state     <= DONE;
                        dm.dm_req <= 1'b0;
                        wait_cnt  <= '0;
                        ld_data   <= 32'd0;
                        timeout   <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: directed cases followed by randomized
// loads/stores, compared against a behavioural model of the access rules.
module tb_dmem_access_ctrl;

    localparam int unsigned MAX_WAIT = 4;

    logic        clk;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic [31:0] ld_data;
    logic        stall;
    logic        misalign;
    logic        timeout;

    dmem_access_ctrl_if dm ();

    dmem_access_ctrl #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .funct3     (funct3),
        .addr       (addr),
        .store_data (store_data),
        .dm         (dm),
        .ld_data    (ld_data),
        .stall      (stall),
        .misalign   (misalign),
        .timeout    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_ld   = 32'd0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // ---- reference model ----
    function automatic int size_of(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input int off,
                                               input logic [31:0] rdata);
        int          sz;
        logic [31:0] v;
        sz = size_of(f3);
        if (sz == 4) return rdata;
        v = rdata >> (8 * off);
        v = (sz == 1) ? (v & 32'hFF) : (v & 32'hFFFF);
        if (f3 == 3'b000 && v >= 32'd128)   v = v - 32'd256;
        if (f3 == 3'b001 && v >= 32'd32768) v = v - 32'd65536;
        return v;
    endfunction

    function automatic logic [3:0] model_we(input logic [2:0] f3, input int off);
        int sz;
        sz = size_of(f3);
        return 4'(((1 << sz) - 1) << off);
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] sd);
        case (size_of(f3))
            1:       return (sd & 32'hFF) * 32'h0101_0101;
            2:       return (sd & 32'hFFFF) * 32'h0001_0001;
            default: return sd;
        endcase
    endfunction

    // One access, entered and left at a negedge with the FSM idle.
    // ack_at: REQ cycle index (0-based) carrying dm_ack, or -1 for never.
    task automatic do_access(input bit wr, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] sd, input int ack_at, input logic [31:0] rdata);
        int          sz;
        int          off;
        logic [31:0] word_addr;
        sz        = size_of(f3);
        off       = int'(a[1:0]);
        word_addr = a & 32'hFFFF_FFFC;

        mem_read   = !wr;
        mem_write  = wr;
        funct3     = f3;
        addr       = a;
        store_data = sd;
        #1;
        check_eq("idle_stall", 32'(stall), 32'd1);
        check_eq("idle_req", 32'(dm.dm_req), 32'd0);

        if ((off % sz) != 0) begin
            @(posedge clk); #1;
            exp_ld = 32'd0;
            check_eq("mis_pulse", 32'(misalign), 32'd1);
            check_eq("mis_stall", 32'(stall), 32'd0);
            check_eq("mis_req", 32'(dm.dm_req), 32'd0);
            check_eq("mis_ld", ld_data, exp_ld);
        end else begin
            @(posedge clk); #1;
            check_eq("req_valid", 32'(dm.dm_req), 32'd1);
            check_eq("req_stall", 32'(stall), 32'd1);
            check_eq("req_addr", dm.dm_addr, word_addr);
            check_eq("req_we", 32'(dm.dm_we), wr ? 32'(model_we(f3, off)) : 32'd0);
            if (wr) check_eq("req_wdata", dm.dm_wdata, model_wdata(f3, sd));
            for (int k = 0; k < int'(MAX_WAIT); k++) begin
                @(negedge clk);
                dm.dm_ack   = (k == ack_at);
                dm.dm_rdata = (k == ack_at) ? rdata : $urandom;
                @(posedge clk); #1;
                if (k == ack_at) begin
                    if (!wr) exp_ld = model_load(f3, off, rdata);
                    check_eq("ack_ld", ld_data, exp_ld);
                    check_eq("ack_req", 32'(dm.dm_req), 32'd0);
                    check_eq("ack_stall", 32'(stall), 32'd0);
                    check_eq("ack_timeout", 32'(timeout), 32'd0);
                    break;
                end else if (k == int'(MAX_WAIT) - 1) begin
                    exp_ld = 32'd0;
                    check_eq("to_pulse", 32'(timeout), 32'd1);
                    check_eq("to_ld", ld_data, exp_ld);
                    check_eq("to_req", 32'(dm.dm_req), 32'd0);
                    check_eq("to_stall", 32'(stall), 32'd0);
                end else begin
                    check_eq("wait_req", 32'(dm.dm_req), 32'd1);
                    check_eq("wait_stall", 32'(stall), 32'd1);
                    check_eq("wait_addr", dm.dm_addr, word_addr);
                    check_eq("wait_ld", ld_data, exp_ld);
                end
            end
        end

        @(negedge clk);
        dm.dm_ack = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        @(posedge clk); #1;
        check_eq("post_misalign", 32'(misalign), 32'd0);
        check_eq("post_timeout", 32'(timeout), 32'd0);
        check_eq("post_req", 32'(dm.dm_req), 32'd0);
        check_eq("post_ld", ld_data, exp_ld);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0]  ld_codes [7];
        logic [2:0]  f3;
        logic [31:0] a;
        int          sz;
        int          off;
        int          ack_at;
        bit          wr;
        ld_codes = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b111};

        rst         = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        funct3      = 3'd0;
        addr        = 32'd0;
        store_data  = 32'd0;
        dm.dm_ack   = 1'b0;
        dm.dm_rdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_req", 32'(dm.dm_req), 32'd0);
        check_eq("rst_we", 32'(dm.dm_we), 32'd0);
        check_eq("rst_addr", dm.dm_addr, 32'd0);
        check_eq("rst_wdata", dm.dm_wdata, 32'd0);
        check_eq("rst_ld", ld_data, 32'd0);
        check_eq("rst_misalign", 32'(misalign), 32'd0);
        check_eq("rst_timeout", 32'(timeout), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        do_access(1'b0, 3'b010, 32'h100, 32'd0, 0, 32'hDEAD_BEEF);
        check_eq("lw_result", ld_data, 32'hDEAD_BEEF);
        do_access(1'b0, 3'b000, 32'h103, 32'd0, 0, 32'h8011_2233);
        check_eq("lb_result", ld_data, 32'hFFFF_FF80);
        do_access(1'b0, 3'b100, 32'h103, 32'd0, 1, 32'h8011_2233);
        check_eq("lbu_result", ld_data, 32'h0000_0080);
        do_access(1'b0, 3'b101, 32'h102, 32'd0, 2, 32'h8011_2233);
        check_eq("lhu_result", ld_data, 32'h0000_8011);
        do_access(1'b1, 3'b000, 32'h202, 32'h0000_00A5, 0, 32'hFFFF_FFFF);
        do_access(1'b1, 3'b001, 32'h202, 32'h0000_1234, 0, 32'hFFFF_FFFF);
        check_eq("store_keeps_ld", ld_data, 32'h0000_8011);

        // Reset in the middle of REQ; a late ack must be dropped.
        mem_read = 1'b1;
        funct3   = 3'b010;
        addr     = 32'h300;
        @(posedge clk); #1;
        check_eq("mid_req", 32'(dm.dm_req), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        exp_ld = 32'd0;
        check_eq("mid_rst_req", 32'(dm.dm_req), 32'd0);
        check_eq("mid_rst_addr", dm.dm_addr, 32'd0);
        check_eq("mid_rst_ld", ld_data, exp_ld);
        mem_read    = 1'b0;
        dm.dm_ack   = 1'b1;
        dm.dm_rdata = 32'h1234_5678;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check_eq("late_ack_ld", ld_data, exp_ld);
        check_eq("late_ack_req", 32'(dm.dm_req), 32'd0);
        check_eq("late_ack_stall", 32'(stall), 32'd0);
        @(negedge clk);
        dm.dm_ack = 1'b0;

        do_access(1'b0, 3'b010, 32'h100, 32'd0, 0, 32'hCAFE_F00D);
        do_access(1'b0, 3'b010, 32'h101, 32'd0, 0, 32'h1111_1111);
        check_eq("misalign_ld", ld_data, 32'd0);
        do_access(1'b0, 3'b010, 32'h100, 32'd0, 0, 32'h5555_AAAA);
        do_access(1'b0, 3'b010, 32'h400, 32'd0, -1, 32'd0);
        check_eq("timeout_ld", ld_data, 32'd0);

        for (int i = 0; i < 160; i++) begin
            wr = ($urandom_range(0, 2) == 0);
            f3 = wr ? 3'($urandom_range(0, 2)) : ld_codes[$urandom_range(0, 6)];
            sz  = size_of(f3);
            off = $urandom_range(0, 3);
            if ($urandom_range(0, 3) != 0) off = off - (off % sz);
            a = ($urandom & 32'hFFFF_FFFC) | 32'(off);
            ack_at = $urandom_range(0, MAX_WAIT);
            if (ack_at == int'(MAX_WAIT)) ack_at = -1;
            do_access(wr, f3, a, $urandom, ack_at, $urandom);
            if ($urandom_range(0, 4) == 0) begin
                // Stray ack while idle must not disturb anything.
                dm.dm_ack   = 1'b1;
                dm.dm_rdata = $urandom;
                @(posedge clk); #1;
                check_eq("stray_ack_ld", ld_data, exp_ld);
                check_eq("stray_ack_req", 32'(dm.dm_req), 32'd0);
                @(negedge clk);
                dm.dm_ack = 1'b0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
